display_mode_controller: RTL and testbench
==========================================

Name: display_mode_controller

Overview:
Sequencer for the single-digit 7-segment count datapath. It runs a power-on segment-chase animation, then uses debounced switch edges to pick one of three counter sources (auto, switch-step, bit-toggle). It publishes the mode to the top-level nibble/segment muxes and returns to the animation when the user holds a two-switch chord. It supersedes the ad-hoc mode logic in the count top level. All inputs are already debounced.

Parameters:
ANIM_TICKS, 6250000, clock cycles per animation step (0.25 s at 25 MHz); legal range >= 2.
HOLD_TICKS, 25000000, clock cycles the S1+S4 chord must be held to leave a run mode (1 s); legal range >= 2.

Ports:
i_Clk  input  1  system clock, all logic on rising edge
i_Rst_L  input  1  asynchronous active-low reset
i_Switches  input  4  debounced switches, bit0=S1 .. bit3=S4, 1=pressed
o_State  output  3  current state encoding (see Behaviour)
o_Segments  output  7  active-high segment pattern, bit0=A .. bit6=G, valid in INIT/RESET_WAIT
o_Counter_Clear  output  1  one-cycle pulse to clear the selected counter on mode entry
o_Anim_Done  output  1  high once the first full animation loop has completed since INIT entry

Behaviour:
- State encoding: INIT=0, AUTO=1, SWITCH=2, BIT=3, RESET_WAIT=4. Codes 5-7 are unreachable; if present, go to INIT on the next clock.
- Reset (i_Rst_L low, async) sets these values:
  - state INIT, o_State=0.
  - o_Segments=7'b0000001 (segment A).
  - animation index 0, tick counter 0, hold counter 0.
  - o_Counter_Clear=0, o_Anim_Done=0.
  - edge-detect history register = 4'b1111, so switches held through reset give no edge.
  - Reset deasserted mid-operation restarts from INIT with these values.
- Edge detection:
  - rise[i] = i_Switches[i] & ~prev[i]; prev updates every cycle.
  - A press sampled on edge N changes state on edge N+1 (one cycle latency from registered input).
- All outputs are registered.
- INIT:
  - Tick counter counts 0..ANIM_TICKS-1. At terminal count the index advances 0..5 and wraps 5->0.
  - o_Segments shows one-hot A,B,C,D,E,F for index 0..5. G is never lit in INIT.
  - o_Anim_Done sets on the first 5->0 wrap and stays set until INIT is re-entered.
  - Mode select is honoured only when o_Anim_Done=1; earlier rises are ignored, not queued.
  - Mode select: rise S1 -> AUTO, rise S2 -> SWITCH, rise S3 -> BIT. Simultaneous rises resolve by priority S1>S2>S3. S4 is ignored.
- Run modes (AUTO, SWITCH, BIT):
  - o_Segments=0. o_Counter_Clear=1 for exactly the first cycle in the state.
  - Hold counter increments each cycle while i_Switches[0]&i_Switches[3]. It clears to 0 on any cycle where either is low.
  - When the hold counter reaches HOLD_TICKS-1 while the chord is still held, go to RESET_WAIT. That is HOLD_TICKS consecutive held cycles.
  - No direct transition between run modes.
- RESET_WAIT:
  - o_Segments=7'b1000000 (G, dash).
  - Stay while any switch is pressed. On the first cycle with i_Switches==0, go to INIT.
  - On that INIT entry: index=0, tick=0, o_Anim_Done=0, hold counter=0.
- Counter widths: ceil(log2(ANIM_TICKS)) and ceil(log2(HOLD_TICKS)), saturating never required because both terminate.

Test Plan:
All scenarios use ANIM_TICKS=4, HOLD_TICKS=16.
1. Assert i_Rst_L=0 mid-cycle, release -> outputs are at reset values immediately (async). o_Segments steps A,B,C,D,E,F every 4 cycles and returns to A at cycle 24. o_Anim_Done rises with the wrap.
2. Pulse S2 at cycle 10 (before done) -> ignored, state stays 0. Pulse S2 after done -> o_State=2 one cycle after the sampled rise, o_Counter_Clear high exactly 1 cycle, o_Segments=0.
3. After done, raise S1 and S3 on the same cycle -> o_State=1 (priority). Hold S1 through reset deassertion -> no mode select until S1 is released and pressed again.
4. In BIT, hold S1+S4 for 15 cycles, release S4 for 1 cycle, then hold 16 cycles -> transition occurs only after the second hold, at cycle 16 of it, to o_State=4 with o_Segments=7'b1000000.
5. In RESET_WAIT, keep S1 pressed 20 cycles then release -> o_State stays 4 until the all-released cycle, then 0. The animation restarts at A with o_Anim_Done=0.
6. Force the state register to 6 via the bench -> o_State=0 on the next clock.

Source files
------------

// File: rtl/display_mode_controller_if.sv
// Switch inputs and mode/segment outputs of the display mode controller,
// bundled so the sequencer and the top-level muxes share one port group.
interface display_mode_controller_if;
   logic [3:0] i_Switches;       // debounced, bit0=S1 .. bit3=S4, 1=pressed
   logic [2:0] o_State;          // current mode encoding
   logic [6:0] o_Segments;       // active-high, bit0=A .. bit6=G
   logic       o_Counter_Clear;  // one-cycle clear on run-mode entry
   logic       o_Anim_Done;      // first animation loop completed

   // Driver of the switches and consumer of the mode outputs
   modport master (
      output i_Switches,
      input  o_State,
      input  o_Segments,
      input  o_Counter_Clear,
      input  o_Anim_Done
   );

   // The sequencer itself
   modport slave (
      input  i_Switches,
      output o_State,
      output o_Segments,
      output o_Counter_Clear,
      output o_Anim_Done
   );
endinterface

// File: rtl/display_mode_controller.sv
// Mode sequencer for the 7-segment count datapath: power-on segment chase,
// switch-edge mode selection (AUTO/SWITCH/BIT), and an S1+S4 hold chord
// that returns to the animation once all switches are released.
module display_mode_controller #(
   parameter int ANIM_TICKS = 6250000,
   parameter int HOLD_TICKS = 25000000
) (
   input  logic                        i_Clk,
   input  logic                        i_Rst_L,
   display_mode_controller_if.slave    bus
);

   typedef enum logic [2:0] {
      ST_INIT       = 3'd0,
      ST_AUTO       = 3'd1,
      ST_SWITCH     = 3'd2,
      ST_BIT        = 3'd3,
      ST_RESET_WAIT = 3'd4
   } state_t;

   localparam int TW = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
   localparam int HW = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
   localparam logic [TW-1:0] C_ANIM_LAST = TW'(ANIM_TICKS - 1);
   localparam logic [HW-1:0] C_HOLD_LAST = HW'(HOLD_TICKS - 1);
   localparam logic [6:0]    C_SEG_A     = 7'b0000001;
   localparam logic [6:0]    C_SEG_DASH  = 7'b1000000;

   // Plain vector so an illegal code (5..7) can be held and recovered from
   logic [2:0]    r_State;
   logic [6:0]    r_Segments;
   logic          r_Counter_Clear;
   logic          r_Anim_Done;
   logic [2:0]    r_Idx;
   logic [TW-1:0] r_Tick;
   logic [HW-1:0] r_Hold;
   // Switches are registered once, then compared to their previous sample;
   // both reset to all-ones so switches held through reset produce no edge.
   logic [3:0]    r_Sw_Sync;
   logic [3:0]    r_Sw_Prev;

   logic [3:0]    w_Rise;
   logic          w_Chord;

   assign w_Rise  = r_Sw_Sync & ~r_Sw_Prev;
   assign w_Chord = bus.i_Switches[0] & bus.i_Switches[3];

   assign bus.o_State         = r_State;
   assign bus.o_Segments      = r_Segments;
   assign bus.o_Counter_Clear = r_Counter_Clear;
   assign bus.o_Anim_Done     = r_Anim_Done;

   // Single registered FSM: state, animation, hold timer and all outputs
   always_ff @(posedge i_Clk or negedge i_Rst_L) begin
      if (!i_Rst_L) begin
         r_State         <= ST_INIT;
         r_Segments      <= C_SEG_A;
         r_Counter_Clear <= 1'b0;
         r_Anim_Done     <= 1'b0;
         r_Idx           <= 3'd0;
         r_Tick          <= '0;
         r_Hold          <= '0;
         r_Sw_Sync       <= 4'b1111;
         r_Sw_Prev       <= 4'b1111;
      end else begin
         r_Sw_Sync       <= bus.i_Switches;
         r_Sw_Prev       <= r_Sw_Sync;
         r_Counter_Clear <= 1'b0;

         case (r_State)
            ST_INIT: begin
               r_Hold <= '0;
               // Segment chase A..F, one step per ANIM_TICKS cycles
               if (r_Tick == C_ANIM_LAST) begin
                  r_Tick <= '0;
                  if (r_Idx == 3'd5) begin
                     r_Idx       <= 3'd0;
                     r_Segments  <= C_SEG_A;
                     r_Anim_Done <= 1'b1;
                  end else begin
                     r_Idx      <= r_Idx + 3'd1;
                     r_Segments <= r_Segments << 1;
                  end
               end else begin
                  r_Tick <= r_Tick + TW'(1);
               end
               // Mode select only after one full loop; earlier edges are dropped
               if (r_Anim_Done && (w_Rise[0] | w_Rise[1] | w_Rise[2])) begin
                  r_Segments      <= 7'b0000000;
                  r_Counter_Clear <= 1'b1;
                  if (w_Rise[0])
                     r_State <= ST_AUTO;
                  else if (w_Rise[1])
                     r_State <= ST_SWITCH;
                  else
                     r_State <= ST_BIT;
               end
            end

            ST_AUTO, ST_SWITCH, ST_BIT: begin
               r_Segments <= 7'b0000000;
               // HOLD_TICKS consecutive chord cycles leave the run mode
               if (w_Chord) begin
                  if (r_Hold == C_HOLD_LAST) begin
                     r_Hold     <= '0;
                     r_Segments <= C_SEG_DASH;
                     r_State    <= ST_RESET_WAIT;
                  end else begin
                     r_Hold <= r_Hold + HW'(1);
                  end
               end else begin
                  r_Hold <= '0;
               end
            end

            ST_RESET_WAIT: begin
               r_Segments <= C_SEG_DASH;
               // Wait for a fully released keypad before restarting the chase
               if (bus.i_Switches == 4'b0000) begin
                  r_State     <= ST_INIT;
                  r_Segments  <= C_SEG_A;
                  r_Idx       <= 3'd0;
                  r_Tick      <= '0;
                  r_Hold      <= '0;
                  r_Anim_Done <= 1'b0;
               end
            end

            default: begin
               r_State     <= ST_INIT;
               r_Segments  <= C_SEG_A;
               r_Idx       <= 3'd0;
               r_Tick      <= '0;
               r_Hold      <= '0;
               r_Anim_Done <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_mode_controller.sv
// Directed bench for display_mode_controller with a cycle-tagged scoreboard:
// expectations are queued for a future clock edge and checked after it.
module tb_display_mode_controller;

   logic clk;
   logic rst_n;
   int   cyc;
   int   checks;
   int   passed;

   typedef struct {
      int          cyc;
      string       tag;
      logic [10:0] v;
   } exp_t;

   exp_t q[$];

   display_mode_controller_if bus ();

   display_mode_controller #(
      .ANIM_TICKS (4),
      .HOLD_TICKS (16)
   ) dut (
      .i_Clk   (clk),
      .i_Rst_L (rst_n),
      .bus     (bus)
   );

   localparam logic [6:0] SA = 7'b0000001;
   localparam logic [6:0] SB = 7'b0000010;
   localparam logic [6:0] SD = 7'b0001000;
   localparam logic [6:0] SF = 7'b0100000;
   localparam logic [6:0] SG = 7'b1000000;
   localparam logic [6:0] S0 = 7'b0000000;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [10:0] observed();
      return {bus.o_State, bus.o_Segments, bus.o_Counter_Clear, bus.o_Anim_Done};
   endfunction

   task automatic check(string tag, logic [10:0] got, logic [10:0] want);
      checks++;
      assert (got === want) passed++;
      else $error("FAIL %s: got st=%0d seg=%b clr=%b done=%b, want st=%0d seg=%b clr=%b done=%b",
                  tag, got[10:8], got[7:1], got[0+1], got[0],
                  want[10:8], want[7:1], want[1], want[0]);
   endtask

   // Queue an expectation for k edges from now, kept sorted by target edge
   task automatic expect_at(int k, string tag, logic [2:0] st, logic [6:0] seg,
                            logic clr, logic done);
      exp_t e;
      int   i;
      e.cyc = cyc + k;
      e.tag = tag;
      e.v   = {st, seg, clr, done};
      i = q.size();
      while (i > 0 && q[i-1].cyc > e.cyc) i--;
      q.insert(i, e);
   endtask

   task automatic drive(logic [3:0] sw, int n);
      bus.i_Switches = sw;
      repeat (n) @(negedge clk);
   endtask

   // Scoreboard: compare every expectation due at this edge
   always @(posedge clk) begin
      exp_t e;
      cyc = cyc + 1;
      #1;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         check(e.tag, observed(), e.v);
      end
   end

   initial begin
      cyc    = 0;
      checks = 0;
      passed = 0;
      bus.i_Switches = 4'b0000;
      rst_n = 1'b1;

      // 1: async reset, then animation steps every 4 cycles, wrap at 24
      #1 rst_n = 1'b0;
      #1 check("reset_async", observed(), {3'd0, SA, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      expect_at(3,  "anim_still_A", 3'd0, SA, 1'b0, 1'b0);
      for (int j = 1; j <= 6; j++)
         expect_at(4 * j, $sformatf("anim_step%0d", j), 3'd0,
                   7'(7'b0000001 << (j % 6)), 1'b0, (j == 6));
      expect_at(23, "anim_F_not_done", 3'd0, SF, 1'b0, 1'b0);
      // 2: early S2 press at cycle 10 is ignored
      expect_at(12, "early_press_ignored", 3'd0, SD, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) begin
         bus.i_Switches = (k == 9) ? 4'b0010 : 4'b0000;
         @(negedge clk);
      end

      // 2: S2 after done -> SWITCH with one-cycle clear
      expect_at(1, "sw_latency", 3'd0, SA, 1'b0, 1'b1);
      expect_at(2, "sw_enter",   3'd2, S0, 1'b1, 1'b1);
      expect_at(3, "sw_clr_off", 3'd2, S0, 1'b0, 1'b1);
      drive(4'b0010, 1);
      drive(4'b0000, 2);

      // Leave SWITCH with a full chord, then release
      expect_at(15, "sw_hold15", 3'd2, S0, 1'b0, 1'b1);
      expect_at(16, "sw_to_rw",  3'd4, SG, 1'b0, 1'b1);
      drive(4'b1001, 16);
      expect_at(1, "rw_to_init", 3'd0, SA, 1'b0, 1'b0);
      drive(4'b0000, 1);

      // 3: simultaneous S1+S3 after done -> AUTO by priority
      expect_at(23, "re_anim_F",   3'd0, SF, 1'b0, 1'b0);
      expect_at(24, "re_anim_done", 3'd0, SA, 1'b0, 1'b1);
      drive(4'b0000, 24);
      expect_at(1, "prio_latency", 3'd0, SA, 1'b0, 1'b1);
      expect_at(2, "prio_auto",    3'd1, S0, 1'b1, 1'b1);
      drive(4'b0101, 2);
      drive(4'b0001, 3);

      // 3: reset mid-cycle with S1 held -> no mode select from that S1
      #2 rst_n = 1'b0;
      #1 check("reset_midop", observed(), {3'd0, SA, 1'b0, 1'b0});
      @(negedge clk);
      rst_n = 1'b1;
      expect_at(24, "held_done",      3'd0, SA, 1'b0, 1'b1);
      expect_at(27, "held_no_select", 3'd0, SA, 1'b0, 1'b1);
      drive(4'b0001, 27);
      drive(4'b0000, 2);
      expect_at(1, "repress_latency", 3'd0, SB, 1'b0, 1'b1);
      expect_at(2, "repress_auto",    3'd1, S0, 1'b1, 1'b1);
      drive(4'b0001, 2);

      // Back through RESET_WAIT to INIT, then select BIT with S3
      expect_at(16, "auto_to_rw", 3'd4, SG, 1'b0, 1'b1);
      drive(4'b1001, 16);
      drive(4'b0000, 24);
      expect_at(2, "bit_enter", 3'd3, S0, 1'b1, 1'b1);
      drive(4'b0100, 2);

      // 4: broken hold (15 + gap) does not exit; a full 16-cycle hold does
      expect_at(15, "bit_hold15",   3'd3, S0, 1'b0, 1'b1);
      expect_at(16, "bit_gap",      3'd3, S0, 1'b0, 1'b1);
      expect_at(31, "bit_rehold15", 3'd3, S0, 1'b0, 1'b1);
      expect_at(32, "bit_to_rw",    3'd4, SG, 1'b0, 1'b1);
      drive(4'b1001, 15);
      drive(4'b0001, 1);
      drive(4'b1001, 16);

      // 5: stay in RESET_WAIT while S1 is held, restart on full release
      expect_at(20, "rw_held",     3'd4, SG, 1'b0, 1'b1);
      expect_at(21, "rw_release",  3'd0, SA, 1'b0, 1'b0);
      expect_at(25, "restart_B",   3'd0, SB, 1'b0, 1'b0);
      drive(4'b0001, 20);
      drive(4'b0000, 5);

      // 6: illegal state code recovers to INIT on the next clock
      force dut.r_State = 3'd6;
      #1 release dut.r_State;
      expect_at(1, "illegal_recover", 3'd0, SA, 1'b0, 1'b0);
      expect_at(5, "illegal_anim_B",  3'd0, SB, 1'b0, 1'b0);
      drive(4'b0000, 6);

      check("scoreboard_drained", {10'd0, (q.size() == 0)}, 11'd1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
